// File: rtl/upsample_pkg.sv
`default_nettype none
// ============================================================================
// Module   : upsample_pkg
// Purpose  : Shared definitions for the 2x nearest-neighbour upsampler:
//            FSM state encoding and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package upsample_pkg;

  localparam int STATE_W = 1;

  // The upsampler alternates between passing a fresh input row through
  // (each pixel doubled) and replaying that row from the line buffer.
  localparam logic [STATE_W-1:0] S_PASS   = 1'b0;
  localparam logic [STATE_W-1:0] S_REPLAY = 1'b1;

  // Counter width for a range of n values; never below one bit so that a
  // degenerate 1-pixel dimension still yields a legal vector.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/upsample_row_mem.sv
`default_nettype none
// ============================================================================
// Module   : upsample_row_mem
// Purpose  : One-row line buffer, DEPTH x 1 bit. Synchronous write port,
//            asynchronous read port.
// Ports    : clk   - clock
//            we    - write enable
//            waddr - write column
//            wdata - write pixel
//            raddr - read column
//            rdata - read pixel (combinational)
// Revision : 1.0  initial release
// ============================================================================
module upsample_row_mem #(
  parameter int DEPTH = 13,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  // Not reset: every location is written during a row's pass before the
  // replay of that row reads it back.
  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/upsample_2x_stream.sv
`default_nettype none
// ============================================================================
// Module   : upsample_2x_stream
// Purpose  : Nearest-neighbour 2x upsampler for 1-bit raster streams.
//            Each input pixel is emitted twice horizontally and each input
//            row is replayed once from a line buffer, so
//            out(x,y) = in(x>>1, y>>1).
// Ports    : clk       - clock, rising edge
//            rst_n     - synchronous active-low reset
//            valid_in  - input pixel valid
//            pixel_in  - input pixel
//            ready_in  - input accepted this cycle (combinational)
//            valid_out - output beat valid (registered)
//            pixel_out - output pixel (registered)
//            sof_out   - first beat of an output frame
//            eol_out   - last beat of an output row
//            ready_out - downstream accepts the output beat
// Revision : 1.0  initial release
// ============================================================================
module upsample_2x_stream
  import upsample_pkg::*;
#(
  parameter int WIDTH_IN  = 13,
  parameter int HEIGHT_IN = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic pixel_in,
  output logic ready_in,
  output logic valid_out,
  output logic pixel_out,
  output logic sof_out,
  output logic eol_out,
  input  logic ready_out
);

  localparam int X_BITS = cnt_bits(WIDTH_IN);
  localparam int Y_BITS = cnt_bits(HEIGHT_IN);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH_IN - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT_IN - 1);
  localparam logic [X_BITS-1:0] X_ONE  = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE  = Y_BITS'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic               h_q, h_d;         // second half of a doubled pixel
  logic [X_BITS-1:0]  xi_q, xi_d;
  logic [Y_BITS-1:0]  yi_q, yi_d;
  logic               hold_q, hold_d;   // pixel being doubled in S_PASS
  logic               valid_out_q, valid_out_d;
  logic               pixel_out_q, pixel_out_d;
  logic               sof_out_q, sof_out_d;
  logic               eol_out_q, eol_out_d;

  logic adv;
  logic x_last;
  logic mem_we;
  logic mem_rdata;

  // The output register may load whenever it is empty or being drained.
  assign adv    = !valid_out_q || ready_out;
  assign x_last = (xi_q == X_LAST);

  upsample_row_mem #(
    .DEPTH (WIDTH_IN),
    .AW    (X_BITS)
  ) u_row_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (xi_q),
    .wdata (pixel_in),
    .raddr (xi_q),
    .rdata (mem_rdata)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_PASS;
      h_q         <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      hold_q      <= 1'b0;
      valid_out_q <= 1'b0;
      pixel_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
      eol_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      hold_q      <= hold_d;
      valid_out_q <= valid_out_d;
      pixel_out_q <= pixel_out_d;
      sof_out_q   <= sof_out_d;
      eol_out_q   <= eol_out_d;
    end
  end

  // Next state: the last beat of a row (second half of the final column)
  // flips between passing and replaying.
  always_comb begin
    state_d = state_q;
    if (adv && h_q && x_last) begin
      state_d = (state_q == S_PASS) ? S_REPLAY : S_PASS;
    end
  end

  // Outputs and datapath.
  always_comb begin
    h_d         = h_q;
    xi_d        = xi_q;
    yi_d        = yi_q;
    hold_d      = hold_q;
    valid_out_d = valid_out_q;
    pixel_out_d = pixel_out_q;
    sof_out_d   = sof_out_q;
    eol_out_d   = eol_out_q;
    mem_we      = 1'b0;
    ready_in    = (state_q == S_PASS) && !h_q && adv;

    if (adv) begin
      // Default to a bubble; pixel_out keeps its last value.
      valid_out_d = 1'b0;
      sof_out_d   = 1'b0;
      eol_out_d   = 1'b0;
      if (state_q == S_PASS) begin
        if (!h_q) begin
          if (valid_in) begin
            pixel_out_d = pixel_in;
            valid_out_d = 1'b1;
            mem_we      = 1'b1;
            hold_d      = pixel_in;
            h_d         = 1'b1;
            sof_out_d   = (xi_q == '0) && (yi_q == '0);
          end
        end else begin
          pixel_out_d = hold_q;
          valid_out_d = 1'b1;
          h_d         = 1'b0;
          if (x_last) begin
            eol_out_d = 1'b1;
            xi_d      = '0;
          end else begin
            xi_d = xi_q + X_ONE;
          end
        end
      end else begin
        pixel_out_d = mem_rdata;
        valid_out_d = 1'b1;
        h_d         = !h_q;
        if (h_q) begin
          if (x_last) begin
            eol_out_d = 1'b1;
            xi_d      = '0;
            yi_d      = (yi_q == Y_LAST) ? '0 : yi_q + Y_ONE;
          end else begin
            xi_d = xi_q + X_ONE;
          end
        end
      end
    end
  end

  assign valid_out = valid_out_q;
  assign pixel_out = pixel_out_q;
  assign sof_out   = sof_out_q;
  assign eol_out   = eol_out_q;

endmodule
`default_nettype wire
